// File: rtl/parallel_mults_pkg.sv
// -----------------------------------------------------------------------------
// parallel_mults_pkg
// Shared constants for the schoolbook polynomial multiplier datapath:
// lane count, accumulator and secret lane widths, and the flattened vector
// widths used on the acc/secret/result ports. Also holds the secret-loader
// counter encoding.
// -----------------------------------------------------------------------------
package parallel_mults_pkg;

  localparam int N_COEFF   = 256;
  localparam int ACC_W     = 13;
  localparam int S_W       = 4;
  localparam int S_WORDS   = N_COEFF * S_W / 64;

  localparam int ACC_VEC_W = N_COEFF * ACC_W;  // 3328
  localparam int S_VEC_W   = N_COEFF * S_W;    // 1024

  // 13-bit coefficient times 3-bit magnitude fits in 16 bits.
  localparam int PROD_W    = 16;

  localparam int ADDR_W    = 8;

  // Loader counter: counts 0..17 and parks at 17 once all words are in.
  localparam int                CNT_W     = 5;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(S_WORDS - 1);  // 15
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(S_WORDS);      // 16
  localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(S_WORDS + 1);  // 17

endpackage

// File: rtl/parallel_mults_lane.sv
// -----------------------------------------------------------------------------
// parallel_mults_lane
// One sign-magnitude multiply-accumulate lane, arithmetic mod 2^ACC_W.
//   a_coeff  in  ACC_W  public coefficient (shared by all lanes)
//   acc_in   in  ACC_W  current accumulator lane
//   s_in     in  S_W    secret lane: [S_W-1] sign (1 = negative), rest magnitude
//   result   out ACC_W  acc_in +/- a_coeff * |s|, wrapped to ACC_W bits
// -----------------------------------------------------------------------------
module parallel_mults_lane
  import parallel_mults_pkg::*;
(
  input  logic [ACC_W-1:0] a_coeff,
  input  logic [ACC_W-1:0] acc_in,
  input  logic [S_W-1:0]   s_in,
  output logic [ACC_W-1:0] result
);

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_t;

  // A zero magnitude gives prod == 0, so -0 and +0 both leave acc unchanged.
  always_comb begin
    prod   = PROD_W'(a_coeff) * PROD_W'(s_in[S_W-2:0]);
    prod_t = prod[ACC_W-1:0];
    result = s_in[S_W-1] ? (acc_in - prod_t) : (acc_in + prod_t);
  end

endmodule

// File: rtl/parallel_mults.sv
// -----------------------------------------------------------------------------
// parallel_mults
// Datapath core of the 256-coefficient schoolbook multiplier (secret s x a).
//   clk, rst          clock, asynchronous active-high reset
//   s_address         BRAM read address for the secret words (1-cycle latency)
//   s_load            parent shifts the BRAM word into its secret register
//   s_load_done       the final secret word is being loaded this cycle
//   tap0..tap12,tap16 a-buffer taps used by the coefficient selector
//   buffer_counter    index within the current 64-bit refill round
//   pol_load_coeff4x  1: buffer words carry 4 x uint16 coefficients
//   a_coeff           selected coefficient
//   acc, secret       accumulator and secret vectors (lane i at i*width)
//   result            per-lane acc + a_coeff * s, mod 2^13
// -----------------------------------------------------------------------------
module parallel_mults
  import parallel_mults_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADDR_W-1:0]    s_address,
  output logic                 s_load,
  output logic                 s_load_done,
  input  logic [ACC_W-1:0]     tap0,
  input  logic [ACC_W-1:0]     tap1,
  input  logic [ACC_W-1:0]     tap2,
  input  logic [ACC_W-1:0]     tap3,
  input  logic [ACC_W-1:0]     tap4,
  input  logic [ACC_W-1:0]     tap5,
  input  logic [ACC_W-1:0]     tap6,
  input  logic [ACC_W-1:0]     tap7,
  input  logic [ACC_W-1:0]     tap8,
  input  logic [ACC_W-1:0]     tap9,
  input  logic [ACC_W-1:0]     tap10,
  input  logic [ACC_W-1:0]     tap11,
  input  logic [ACC_W-1:0]     tap12,
  input  logic [ACC_W-1:0]     tap16,
  input  logic [3:0]           buffer_counter,
  input  logic                 pol_load_coeff4x,
  output logic [ACC_W-1:0]     a_coeff,
  input  logic [ACC_VEC_W-1:0] acc,
  input  logic [S_VEC_W-1:0]   secret,
  output logic [ACC_VEC_W-1:0] result
);

  // ---------------------------------------------------------------------------
  // Secret loader. The address leads the load strobe by one cycle to cover
  // the BRAM read latency, so cnt runs one step past the last address.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] addr_sat;

  always_comb begin
    cnt_d = (cnt_q < CNT_DONE) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    addr_sat    = (cnt_q > LAST_ADDR) ? LAST_ADDR : cnt_q;
    s_address   = ADDR_W'(addr_sat);
    s_load      = (cnt_q != '0) && (cnt_q <= LAST_LOAD);
    s_load_done = (cnt_q == LAST_LOAD);
  end

  // ---------------------------------------------------------------------------
  // Coefficient selector. In coeff4x mode each 64-bit word holds four
  // coefficients: the first comes from tap16, the rest shift through tap12.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns a_coeff and no latch is inferred.
    a_coeff = tap12;
    if (pol_load_coeff4x) begin
      if (buffer_counter == 4'd0) a_coeff = tap16;
    end else begin
      case (buffer_counter)
        4'd0:    a_coeff = tap0;
        4'd1:    a_coeff = tap1;
        4'd2:    a_coeff = tap2;
        4'd3:    a_coeff = tap3;
        4'd4:    a_coeff = tap4;
        4'd5:    a_coeff = tap5;
        4'd6:    a_coeff = tap6;
        4'd7:    a_coeff = tap7;
        4'd8:    a_coeff = tap8;
        4'd9:    a_coeff = tap9;
        4'd10:   a_coeff = tap10;
        4'd11:   a_coeff = tap11;
        default: a_coeff = tap12;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // MAC lanes. Lanes are independent; the negacyclic wrap is the parent's job.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_COEFF; i++) begin : g_lane
    parallel_mults_lane u_lane (
      .a_coeff (a_coeff),
      .acc_in  (acc[i*ACC_W +: ACC_W]),
      .s_in    (secret[i*S_W +: S_W]),
      .result  (result[i*ACC_W +: ACC_W])
    );
  end

endmodule

// File: tb/tb_parallel_mults.sv
module tb_parallel_mults;
  import parallel_mults_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [ADDR_W-1:0]    s_address;
  logic                 s_load;
  logic                 s_load_done;
  logic [ACC_W-1:0]     tap [0:11];
  logic [ACC_W-1:0]     tap12;
  logic [ACC_W-1:0]     tap16;
  logic [3:0]           buffer_counter;
  logic                 pol_load_coeff4x;
  logic [ACC_W-1:0]     a_coeff;
  logic [ACC_VEC_W-1:0] acc;
  logic [S_VEC_W-1:0]   secret;
  logic [ACC_VEC_W-1:0] result;

  int n_total = 0;
  int n_bad   = 0;

  logic [ACC_VEC_W-1:0] exp_q [$];

  parallel_mults dut (
    .clk              (clk),
    .rst              (rst),
    .s_address        (s_address),
    .s_load           (s_load),
    .s_load_done      (s_load_done),
    .tap0             (tap[0]),
    .tap1             (tap[1]),
    .tap2             (tap[2]),
    .tap3             (tap[3]),
    .tap4             (tap[4]),
    .tap5             (tap[5]),
    .tap6             (tap[6]),
    .tap7             (tap[7]),
    .tap8             (tap[8]),
    .tap9             (tap[9]),
    .tap10            (tap[10]),
    .tap11            (tap[11]),
    .tap12            (tap12),
    .tap16            (tap16),
    .buffer_counter   (buffer_counter),
    .pol_load_coeff4x (pol_load_coeff4x),
    .a_coeff          (a_coeff),
    .acc              (acc),
    .secret           (secret),
    .result           (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Golden lane model using signed integer arithmetic, then wrapped mod 2^13.
  function automatic logic [ACC_W-1:0] mac_model(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] acc_l,
                                                 input logic [S_W-1:0]   s);
    int r;
    int p;
    p = int'(a) * int'(s[2:0]);
    r = s[3] ? int'(acc_l) - p : int'(acc_l) + p;
    r = r % 8192;
    if (r < 0) r += 8192;
    return ACC_W'(r);
  endfunction

  function automatic logic [ACC_W-1:0] sel_model(input logic c4x, input logic [3:0] bc);
    if (c4x) return (bc == 4'd0) ? tap16 : tap12;
    if (bc < 4'd12) return tap[bc];
    return tap12;
  endfunction

  // Drive one MAC vector via tap16 (coeff4x, counter 0), push the expected
  // result vector, let it settle, then pop and compare every lane.
  task automatic apply_mac(input string tag, input logic [ACC_W-1:0] a);
    logic [ACC_VEC_W-1:0] expv;
    logic [ACC_VEC_W-1:0] head;
    pol_load_coeff4x = 1'b1;
    buffer_counter   = 4'd0;
    tap16            = a;
    for (int i = 0; i < N_COEFF; i++)
      expv[i*ACC_W +: ACC_W] = mac_model(a, acc[i*ACC_W +: ACC_W], secret[i*S_W +: S_W]);
    exp_q.push_back(expv);
    #1;
    head = exp_q.pop_front();
    for (int i = 0; i < N_COEFF; i++)
      check($sformatf("%s_lane%0d", tag, i), 32'(result[i*ACC_W +: ACC_W]),
            32'(head[i*ACC_W +: ACC_W]));
  endtask

  task automatic fill_secret(input logic [S_W-1:0] s);
    for (int i = 0; i < N_COEFF; i++) secret[i*S_W +: S_W] = s;
  endtask

  // Checks cycles 0..n-1 after reset release; caller stands #1 after the
  // releasing negedge. Returns the number of s_load pulses seen.
  task automatic run_loader(input string tag, input int n, output int pulses);
    int exp_addr;
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      exp_addr = (k > 15) ? 15 : k;
      check($sformatf("%s_addr_c%0d", tag, k), 32'(s_address), 32'(exp_addr));
      check($sformatf("%s_load_c%0d", tag, k), 32'(s_load), 32'((k >= 1) && (k <= 16)));
      check($sformatf("%s_done_c%0d", tag, k), 32'(s_load_done), 32'(k == 16));
      if (s_load) pulses++;
    end
  endtask

  initial begin
    int pulses;
    logic [ACC_W-1:0] a_r;

    rst              = 1'b1;
    buffer_counter   = '0;
    pol_load_coeff4x = 1'b0;
    tap12            = '0;
    tap16            = '0;
    acc              = '0;
    secret           = '0;
    for (int i = 0; i < 12; i++) tap[i] = '0;

    // Reset state.
    #2;
    check("rst_addr", 32'(s_address), 32'd0);
    check("rst_load", 32'(s_load), 32'd0);
    check("rst_done", 32'(s_load_done), 32'd0);

    // Full load sequence after release.
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_loader("ld", 22, pulses);
    check("ld_pulses", 32'(pulses), 32'd16);

    // Restart, then reset asynchronously in the middle of the load.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_loader("pre", 9, pulses);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_addr", 32'(s_address), 32'd0);
    check("midrst_load", 32'(s_load), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_loader("rld", 20, pulses);
    check("rld_pulses", 32'(pulses), 32'd16);

    // Selector with distinct taps, both modes, every counter value.
    for (int i = 0; i < 12; i++) tap[i] = ACC_W'(13'h0101 + i * 13'h0123);
    tap12 = 13'h1ABC;
    tap16 = 13'h0F0F;
    pol_load_coeff4x = 1'b0;
    buffer_counter = 4'd3;  #1; check("sel_bc3",  32'(a_coeff), 32'(tap[3]));
    buffer_counter = 4'd11; #1; check("sel_bc11", 32'(a_coeff), 32'(tap[11]));
    buffer_counter = 4'd12; #1; check("sel_bc12", 32'(a_coeff), 32'(tap12));
    buffer_counter = 4'd15; #1; check("sel_bc15", 32'(a_coeff), 32'(tap12));
    pol_load_coeff4x = 1'b1;
    buffer_counter = 4'd0;  #1; check("sel4x_bc0", 32'(a_coeff), 32'(tap16));
    buffer_counter = 4'd1;  #1; check("sel4x_bc1", 32'(a_coeff), 32'(tap12));
    buffer_counter = 4'd7;  #1; check("sel4x_bc7", 32'(a_coeff), 32'(tap12));
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 16; b++) begin
        pol_load_coeff4x = m[0];
        buffer_counter   = 4'(b);
        #1;
        check($sformatf("sel_m%0d_bc%0d", m, b), 32'(a_coeff), 32'(sel_model(m[0], 4'(b))));
      end
    end

    // Directed MAC cases, all acc lanes = 0x1FFF.
    acc = {N_COEFF{13'h1FFF}};
    fill_secret(4'b0011);
    apply_mac("mac_p3", 13'd5);
    check("mac_p3_l0", 32'(result[12:0]), 32'h000E);
    fill_secret(4'b1011);
    apply_mac("mac_n3", 13'd5);
    check("mac_n3_l255", 32'(result[ACC_VEC_W-1 -: ACC_W]), 32'h1FF0);
    fill_secret(4'b1000);
    apply_mac("mac_negzero", 13'd5);
    check("mac_negzero_l0", 32'(result[12:0]), 32'h1FFF);
    fill_secret(4'b0111);
    apply_mac("mac_max", 13'h1FFF);
    // (-1) + 7 * (-1) = -8 mod 8192
    check("mac_max_l0", 32'(result[12:0]), 32'h1FF8);

    // Random vectors against the golden model.
    for (int v = 0; v < 1000; v++) begin
      for (int i = 0; i < N_COEFF; i++) begin
        acc[i*ACC_W +: ACC_W] = ACC_W'($urandom);
        secret[i*S_W +: S_W]  = S_W'($urandom);
      end
      a_r = ACC_W'($urandom);
      apply_mac($sformatf("rnd%0d", v), a_r);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
